// File: rtl/con3_servo_rx.sv
// con3_servo_rx
//   Decodes the CON3 hobby-servo PWM line. The high-pulse width is measured in
//   ticks of a TICK_DIV-divided time base. A width of 256+N ticks decodes to
//   angle code N. Widths outside 256..511 saturate to 0x00 or 0xFF and set
//   out_of_range.
//
//   Optional build macro CON3_RX_GLITCH_FILTER_EN:
//     When defined, a 4-cycle persistence filter follows the synchronizer.
//     Pulses or gaps of 3 clk cycles or fewer are ignored.
//     Decode latency grows from 3 to 7 clk cycles.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   en           receiver enable; low forces IDLE and discards any pulse in flight
//   servo        asynchronous servo PWM input
//   angle[7:0]   last decoded angle code
//   valid        one-cycle strobe when angle/out_of_range update
//   out_of_range last pulse fell outside 256..511 ticks (or was aborted)
//   signal_lost  no accepted pulse within TIMEOUT_TICKS of low time
module con3_servo_rx #(
  parameter int TICK_DIV       = 390,
  parameter int TIMEOUT_TICKS  = 6400,
  parameter int MAX_HIGH_TICKS = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       servo,
  output logic [7:0] angle,
  output logic       valid,
  output logic       out_of_range,
  output logic       signal_lost
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = $clog2(TIMEOUT_TICKS + 1);
  localparam int WW = 10;

  typedef enum logic [1:0] {IDLE, ARM, WAIT_RISE, HIGH} state_t;

  state_t        state, state_nx;
  logic          s1, s2, sig, prev;
  logic          rise, fall, tick;
  logic [TW-1:0] tcnt;
  logic [LW-1:0] lcnt;
  logic [WW-1:0] wcnt;
  logic [WW:0]   wnow;
  logic          upd, abort_hit, lost_hit;

  // Two-flop synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= servo;
      s2 <= s1;
    end
  end

`ifdef CON3_RX_GLITCH_FILTER_EN
  // Filtered level follows s2 only after 4 consecutive differing cycles
  logic [1:0] fcnt;
  logic       filt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt <= '0;
      filt <= 1'b0;
    end else if (s2 != filt) begin
      if (fcnt == 2'd3) begin
        filt <= s2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 2'd1;
      end
    end else begin
      fcnt <= '0;
    end
  end
  assign sig = filt;
`else
  assign sig = s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= sig;
  end

  assign rise = sig & ~prev;
  assign fall = ~sig & prev;
  assign tick = (tcnt == TW'(TICK_DIV - 1));

  // Width including a tick landing in the same cycle as the falling edge,
  // so a pulse of H clk cycles measures exactly floor(H / TICK_DIV) ticks.
  assign wnow = {1'b0, wcnt} + {{WW{1'b0}}, tick};

  // Time base; restarted on every rising edge so the measurement is phase-aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           tcnt <= '0;
    else if (state == IDLE || rise || tick) tcnt <= '0;
    else                               tcnt <= tcnt + TW'(1);
  end

  // Width counter, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 wcnt <= '0;
    else if (state != HIGH)  wcnt <= '0;
    else if (tick && wcnt != '1) wcnt <= wcnt + WW'(1);
  end

  // Low-time counter, saturating at TIMEOUT_TICKS
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      lcnt <= '0;
    else if (state != WAIT_RISE)  lcnt <= '0;
    else if (tick && lcnt != LW'(TIMEOUT_TICKS)) lcnt <= lcnt + LW'(1);
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:      state_nx = ARM;
        ARM:       if (!sig) state_nx = WAIT_RISE;
        WAIT_RISE: if (rise) state_nx = HIGH;
        HIGH: begin
          if (fall)           state_nx = WAIT_RISE;
          else if (abort_hit) state_nx = ARM;
        end
        default:   state_nx = IDLE;
      endcase
    end
  end

  // FSM: output decisions
  always_comb begin
    upd       = 1'b0;
    abort_hit = 1'b0;
    lost_hit  = 1'b0;
    if (en) begin
      case (state)
        HIGH: begin
          upd       = fall;
          abort_hit = !fall && tick && (int'(wnow) >= MAX_HIGH_TICKS);
        end
        WAIT_RISE: lost_hit = tick && (lcnt == LW'(TIMEOUT_TICKS - 1));
        default: ;
      endcase
    end
  end

  // Result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle        <= 8'h00;
      valid        <= 1'b0;
      out_of_range <= 1'b0;
      signal_lost  <= 1'b1;
    end else begin
      valid <= upd;
      if (upd) begin
        signal_lost <= 1'b0;
        if (wnow < (WW+1)'(256)) begin
          angle        <= 8'h00;
          out_of_range <= 1'b1;
        end else if (wnow <= (WW+1)'(511)) begin
          angle        <= wnow[7:0];   // low byte of W-256 for W in 256..511
          out_of_range <= 1'b0;
        end else begin
          angle        <= 8'hFF;
          out_of_range <= 1'b1;
        end
      end else if (abort_hit) begin
        out_of_range <= 1'b1;
        signal_lost  <= 1'b1;
      end else if (lost_hit) begin
        signal_lost  <= 1'b1;
      end
    end
  end

endmodule
